// File: rtl/mips32_prog_loader.sv
// rtl/mips32_prog_loader.sv - byte-stream program loader, core run control and register dump for pipe_MIPS32
module mips32_prog_loader #(
    parameter int ADDR_W   = 10,
    parameter int REG_DUMP = 6
) (
    input  logic              clk1,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_hold,
    output logic              core_init,
    input  logic              core_halted,
    output logic [4:0]        reg_raddr,
    input  logic [31:0]       reg_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_LOAD,
        S_START,
        S_RUN,
        S_DUMP
    } state_t;

    localparam logic [16:0] CAPACITY = 17'(2 ** ADDR_W);
    localparam logic [4:0]  LAST_REG = 5'(REG_DUMP - 1);

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       widx_q, widx_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [23:0]       asm_q, asm_d;
    logic [31:0]       shift_q, shift_d;
    logic              dump_cap_q, dump_cap_d;
    logic              rx_ready_q, rx_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              core_hold_q, core_hold_d;
    logic              core_init_q, core_init_d;
    logic [4:0]        reg_raddr_q, reg_raddr_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              overflow_q, overflow_d;
    logic              rx_fire;
    logic              tx_fire;

    assign rx_fire = rx_valid & rx_ready_q;
    assign tx_fire = tx_valid_q & tx_ready;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        widx_d      = widx_q;
        bcnt_d      = bcnt_q;
        asm_d       = asm_q;
        shift_d     = shift_q;
        dump_cap_d  = dump_cap_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        reg_raddr_d = reg_raddr_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        done_d      = 1'b0;
        overflow_d  = overflow_q;

        case (state_q)
            S_LEN_HI: begin
                if (rx_fire) begin
                    len_d[15:8] = rx_data;
                    overflow_d  = 1'b0;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (rx_fire) begin
                    len_d[7:0] = rx_data;
                    widx_d     = 16'd0;
                    bcnt_d     = 2'd0;
                    state_d    = ({len_q[15:8], rx_data} == 16'd0) ? S_START : S_LOAD;
                end
            end
            S_LOAD: begin
                // One drain cycle after the final word so its write completes before START.
                if (widx_q == len_q) begin
                    state_d = S_START;
                end else if (rx_fire) begin
                    bcnt_d = bcnt_q + 2'd1;
                    asm_d  = {asm_q[15:0], rx_data};
                    if (bcnt_q == 2'd3) begin
                        widx_d = widx_q + 16'd1;
                        if ({1'b0, widx_q} < CAPACITY) begin
                            mem_we_d    = 1'b1;
                            mem_addr_d  = widx_q[ADDR_W-1:0];
                            mem_wdata_d = {asm_q, rx_data};
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                end
            end
            S_START: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                // core_hold_q is still high in the first RUN cycle, masking a stale HALTED.
                if (!core_hold_q && core_halted) begin
                    state_d     = S_DUMP;
                    reg_raddr_d = 5'd0;
                    dump_cap_d  = 1'b1;
                end
            end
            S_DUMP: begin
                if (dump_cap_q) begin
                    shift_d    = {reg_rdata[23:0], 8'h00};
                    tx_data_d  = reg_rdata[31:24];
                    tx_valid_d = 1'b1;
                    bcnt_d     = 2'd0;
                    dump_cap_d = 1'b0;
                end else if (tx_fire) begin
                    if (bcnt_q != 2'd3) begin
                        tx_data_d = shift_q[31:24];
                        shift_d   = {shift_q[23:0], 8'h00};
                        bcnt_d    = bcnt_q + 2'd1;
                    end else begin
                        tx_valid_d = 1'b0;
                        if (reg_raddr_q == LAST_REG) begin
                            done_d      = 1'b1;
                            reg_raddr_d = 5'd0;
                            state_d     = S_LEN_HI;
                        end else begin
                            reg_raddr_d = reg_raddr_q + 5'd1;
                            dump_cap_d  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_LEN_HI;
        endcase

        rx_ready_d  = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                      ((state_d == S_LOAD) && (widx_d != len_d));
        core_hold_d = !((state_d == S_RUN) && (state_q == S_RUN));
        core_init_d = (state_q == S_START);
        busy_d      = (state_d != S_LEN_HI);
    end

    always_ff @(posedge clk1) begin
        if (reset) begin
            state_q     <= S_LEN_HI;
            len_q       <= 16'd0;
            widx_q      <= 16'd0;
            bcnt_q      <= 2'd0;
            asm_q       <= 24'd0;
            shift_q     <= 32'd0;
            dump_cap_q  <= 1'b0;
            rx_ready_q  <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            core_hold_q <= 1'b1;
            core_init_q <= 1'b0;
            reg_raddr_q <= 5'd0;
            tx_data_q   <= 8'd0;
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            widx_q      <= widx_d;
            bcnt_q      <= bcnt_d;
            asm_q       <= asm_d;
            shift_q     <= shift_d;
            dump_cap_q  <= dump_cap_d;
            rx_ready_q  <= rx_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            core_hold_q <= core_hold_d;
            core_init_q <= core_init_d;
            reg_raddr_q <= reg_raddr_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
        end
    end

    assign rx_ready  = rx_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign core_hold = core_hold_q;
    assign core_init = core_init_q;
    assign reg_raddr = reg_raddr_q;
    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_mips32_prog_loader.sv
// tb/tb_mips32_prog_loader.sv - self-checking bench for mips32_prog_loader
module tb_mips32_prog_loader;

    logic clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    logic        reset    = 1'b1;
    logic [7:0]  rx_data  = 8'h00;
    logic        rx_valid = 1'b0;
    logic        sel2     = 1'b0;
    logic        tx_ready = 1'b1;

    logic        rx_ready0, mem_we0, core_hold0, core_init0, tx_valid0, busy0, done0, overflow0;
    logic [9:0]  mem_addr0;
    logic [31:0] mem_wdata0, reg_rdata0;
    logic [4:0]  reg_raddr0;
    logic [7:0]  tx_data0;
    logic        core_halted_m = 1'b1;

    logic        rx_ready1, mem_we1, core_hold1, core_init1, tx_valid1, busy1, done1, overflow1;
    logic [1:0]  mem_addr1;
    logic [31:0] mem_wdata1;
    logic [4:0]  reg_raddr1;
    logic [7:0]  tx_data1;
    logic        halted1   = 1'b1;
    logic        tx_ready1 = 1'b1;
    logic [31:0] rdata1    = 32'h0;

    logic [31:0] regs [32];
    assign reg_rdata0 = regs[reg_raddr0];

    mips32_prog_loader #(.ADDR_W(10), .REG_DUMP(6)) dut0 (
        .clk1(clk1), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid & ~sel2),
        .rx_ready(rx_ready0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
        .core_hold(core_hold0), .core_init(core_init0), .core_halted(core_halted_m),
        .reg_raddr(reg_raddr0), .reg_rdata(reg_rdata0), .tx_data(tx_data0), .tx_valid(tx_valid0),
        .tx_ready(tx_ready), .busy(busy0), .done(done0), .overflow(overflow0));

    mips32_prog_loader #(.ADDR_W(2), .REG_DUMP(6)) dut1 (
        .clk1(clk1), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid & sel2),
        .rx_ready(rx_ready1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .core_hold(core_hold1), .core_init(core_init1), .core_halted(halted1),
        .reg_raddr(reg_raddr1), .reg_rdata(rdata1), .tx_data(tx_data1), .tx_valid(tx_valid1),
        .tx_ready(tx_ready1), .busy(busy1), .done(done1), .overflow(overflow1));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_acc = 0;
    int run_cnt  = 0;

    function automatic void check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endfunction

    // Core stand-in: init clears HALTED, then it runs a few unheld cycles and halts.
    always @(posedge clk1) begin
        cyc <= cyc + 1;
        if (core_init0) begin
            core_halted_m <= 1'b0;
            run_cnt       <= 0;
        end else if (!core_hold0 && !core_halted_m) begin
            run_cnt <= run_cnt + 1;
            if (run_cnt == 4) core_halted_m <= 1'b1;
        end
    end

    logic [31:0] wa0[$], wd0[$], wc0[$], wa1[$], wd1[$], ic0[$], ih0[$], tq0[$], exp_wc[$];
    logic [31:0] prog[$];
    int          hold_low  = 0;
    int          done_cnt  = 0;
    int          done1_cnt = 0;
    logic        done_busy = 1'b1;
    logic        pend      = 1'b0;
    logic [7:0]  pend_data = 8'h00;

    always @(negedge clk1) begin
        if (!reset) begin
            if (mem_we0) begin wa0.push_back(32'(mem_addr0)); wd0.push_back(mem_wdata0); wc0.push_back(cyc); end
            if (mem_we1) begin wa1.push_back(32'(mem_addr1)); wd1.push_back(mem_wdata1); end
            if (core_init0) begin ic0.push_back(cyc); ih0.push_back(32'(core_hold0)); end
            if (!core_hold0) hold_low++;
            if (tx_valid0 && tx_ready) tq0.push_back(32'(tx_data0));
            if (done0) begin done_cnt++; done_busy = busy0; end
            if (done1) done1_cnt++;
            if (pend) check("tx_stable", {23'h0, tx_valid0, tx_data0}, {23'h0, 1'b1, pend_data});
            pend      = tx_valid0 && !tx_ready;
            pend_data = tx_data0;
        end else begin
            pend = 1'b0;
        end
    end

    task automatic clear_logs();
        wa0.delete(); wd0.delete(); wc0.delete(); wa1.delete(); wd1.delete();
        ic0.delete(); ih0.delete(); tq0.delete();
        hold_low = 0; done_cnt = 0; done1_cnt = 0; done_busy = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gapmax);
        int  n;
        bit  acc;
        if (gapmax > 0) repeat ($urandom_range(gapmax)) begin @(posedge clk1); #1; end
        rx_data  = b;
        rx_valid = 1'b1;
        n        = 0;
        acc      = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clk1);
            acc = sel2 ? rx_ready1 : rx_ready0;
            @(posedge clk1); #1;
            n++;
        end
        rx_valid = 1'b0;
        if (!acc) check("rx_accept_timeout", 32'd0, 32'd1);
        last_acc = cyc;
    endtask

    task automatic send_prog(input int gapmax);
        logic [31:0] w;
        logic [15:0] n;
        n = 16'(prog.size());
        exp_wc.delete();
        send_byte(n[15:8], gapmax);
        send_byte(n[7:0], gapmax);
        foreach (prog[i]) begin
            w = prog[i];
            for (int j = 3; j >= 0; j--) send_byte(w[8*j +: 8], gapmax);
            exp_wc.push_back(last_acc);
        end
    endtask

    task automatic check_reset_values();
        check("rst_rx_ready",  32'(rx_ready0),  32'd1);
        check("rst_core_hold", 32'(core_hold0), 32'd1);
        check("rst_mem_we",    32'(mem_we0),    32'd0);
        check("rst_mem_addr",  32'(mem_addr0),  32'd0);
        check("rst_mem_wdata", mem_wdata0,      32'd0);
        check("rst_core_init", 32'(core_init0), 32'd0);
        check("rst_reg_raddr", 32'(reg_raddr0), 32'd0);
        check("rst_tx_data",   32'(tx_data0),   32'd0);
        check("rst_tx_valid",  32'(tx_valid0),  32'd0);
        check("rst_busy",      32'(busy0),      32'd0);
        check("rst_done",      32'(done0),      32'd0);
        check("rst_overflow",  32'(overflow0),  32'd0);
    endtask

    task automatic run_and_check(input int gapmax, input bit stall);
        int  t;
        bit  stall_done;
        int  nw;
        int  nb;
        logic [31:0] r;
        clear_logs();
        send_prog(gapmax);
        t          = 0;
        stall_done = 1'b0;
        while (done_cnt == 0 && t < 4000) begin
            if (stall && !stall_done && tq0.size() >= 5) begin
                tx_ready = 1'b0;
                repeat (3) begin @(posedge clk1); #1; end
                tx_ready   = 1'b1;
                stall_done = 1'b1;
            end
            @(posedge clk1); #1;
            t++;
        end
        repeat (3) begin @(posedge clk1); #1; end
        check("done_once", done_cnt, 32'd1);
        check("busy_at_done", 32'(done_busy), 32'd0);
        check("write_count", wa0.size(), prog.size());
        nw = (wa0.size() < prog.size()) ? wa0.size() : prog.size();
        for (int i = 0; i < nw; i++) begin
            check("write_addr", wa0[i], i);
            check("write_data", wd0[i], prog[i]);
            check("write_cycle", wc0[i], exp_wc[i]);
        end
        check("init_count", ic0.size(), 32'd1);
        if (ic0.size() > 0) begin
            check("init_cycle", ic0[0], last_acc + ((prog.size() == 0) ? 1 : 2));
            check("init_hold", ih0[0], 32'd1);
        end
        check("hold_low_in_run", 32'(hold_low > 0), 32'd1);
        check("tx_count", tq0.size(), 32'd24);
        nb = (tq0.size() < 24) ? tq0.size() : 24;
        for (int i = 0; i < nb; i++) begin
            r = regs[i / 4];
            check("tx_byte", tq0[i], 32'(r[8*(3 - i % 4) +: 8]));
        end
    endtask

    initial begin
        int t;
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        repeat (3) @(posedge clk1);
        #1 reset = 1'b0;
        check_reset_values();

        // Reference program and its final register values.
        prog = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
                 32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
        regs[0] = 32'd0;  regs[1] = 32'd10; regs[2] = 32'd20;
        regs[3] = 32'd25; regs[4] = 32'd30; regs[5] = 32'd55;
        run_and_check(0, 1'b0);

        // Same program with random rx gaps and a mid-register tx stall.
        for (int i = 0; i < 6; i++) regs[i] = $urandom;
        run_and_check(3, 1'b1);

        // Random program content.
        prog.delete();
        for (int i = 0; i < 5; i++) prog.push_back($urandom);
        for (int i = 0; i < 6; i++) regs[i] = $urandom;
        run_and_check(2, 1'b0);

        // Empty program.
        prog.delete();
        run_and_check(0, 1'b0);

        // Overflow on a 4-word memory.
        sel2 = 1'b1;
        clear_logs();
        prog.delete();
        for (int i = 0; i < 5; i++) prog.push_back($urandom);
        send_prog(1);
        check("ovf_set", 32'(overflow1), 32'd1);
        check("ovf_write_count", wa1.size(), 32'd4);
        for (int i = 0; i < 4 && i < wa1.size(); i++) begin
            check("ovf_write_addr", wa1[i], i);
            check("ovf_write_data", wd1[i], prog[i]);
        end
        t = 0;
        while (done1_cnt == 0 && t < 2000) begin @(posedge clk1); #1; t++; end
        check("ovf_done", done1_cnt, 32'd1);
        check("ovf_sticky", 32'(overflow1), 32'd1);
        send_byte(8'h00, 0);
        check("ovf_cleared", 32'(overflow1), 32'd0);
        send_byte(8'h00, 0);
        done1_cnt = 0;
        t = 0;
        while (done1_cnt == 0 && t < 2000) begin @(posedge clk1); #1; t++; end
        check("ovf_idle_done", done1_cnt, 32'd1);
        sel2 = 1'b0;

        // Reset after two bytes of the third word.
        prog = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        for (int i = 0; i < 2; i++)
            for (int j = 3; j >= 0; j--) send_byte(8'(prog[i] >> (8 * j)), 0);
        send_byte(8'h33, 0);
        send_byte(8'h33, 0);
        reset = 1'b1;
        @(posedge clk1); #1;
        reset = 1'b0;
        check_reset_values();
        prog = '{32'hdeadbeef};
        for (int i = 0; i < 6; i++) regs[i] = $urandom;
        run_and_check(1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
